// File: rtl/mult_8_bits_pkg.sv
// Shared constants and state encoding for the 8-bit shift-and-add multiplier.
package mult_8_bits_pkg;
    localparam int WIDTH = 8;
    localparam int STEPS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mult_state_t;
endpackage

// File: rtl/full_adder_8_bits_structure.sv
// Structural 8-bit ripple-carry adder built from per-bit gate-level full adders.
module full_adder_8_bits_structure (
    input  logic       CIN,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] S,
    output logic       COUT
);
    logic [8:0] w_c;

    assign w_c[0] = CIN;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        logic w_axb;
        assign w_axb    = A[i] ^ B[i];
        assign S[i]     = w_axb ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_axb & w_c[i]);
    end

    assign COUT = w_c[8];
endmodule

// File: rtl/multiplier_8_bits_shift_add.sv
// Sequential 8x8 unsigned multiplier: one shift-and-add step per clock, 16-bit product
// registered on the final step and flagged with a one-cycle DONE.
module multiplier_8_bits_shift_add
    import mult_8_bits_pkg::*;
#(
    parameter int WIDTH = mult_8_bits_pkg::WIDTH
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               BUSY,
    output logic               DONE
);
    if (WIDTH != 8) begin : g_width_check
        $error("multiplier_8_bits_shift_add: WIDTH must be 8 (adder is fixed at 8 bits)");
    end

    mult_state_t          r_state;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_q;
    logic [2:0]           r_cnt;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [2*WIDTH:0]     w_sel;
    logic [2*WIDTH-1:0]   w_next;
    logic                 w_last;
    logic                 w_accept;

    full_adder_8_bits_structure u_adder (
        .CIN  (1'b0),
        .A    (r_acc),
        .B    (r_m),
        .S    (w_sum),
        .COUT (w_cout)
    );

    // The adder carry lands in ACC[7] after the shift, so the 9-bit sum is never lost.
    assign w_sel    = r_q[0] ? {w_cout, w_sum, r_q} : {1'b0, r_acc, r_q};
    assign w_next   = w_sel[2*WIDTH:1];
    assign w_last   = (r_cnt == 3'(STEPS - 1));
    assign w_accept = START && (r_state == IDLE || r_state == FIN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= w_accept ? RUN : IDLE;
                RUN:     r_state <= w_last ? FIN : RUN;
                FIN:     r_state <= w_accept ? RUN : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_m   <= A;
            r_q   <= B;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_acc <= w_next[2*WIDTH-1:WIDTH];
            r_q   <= w_next[WIDTH-1:0];
            r_cnt <= r_cnt + 3'd1;
            if (w_last) begin
                r_p <= w_next;
            end
        end
    end

    assign P    = r_p;
    assign BUSY = (r_state == RUN);
    assign DONE = (r_state == FIN);
endmodule
